mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_responder_store.sv | 34 +++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, address window
// base and the default geometry of the storage.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [63:0] MEM_BASE_ADDR          = 64'h0000_0000_8000_0000;
  localparam int unsigned MEM_DEFAULT_DATA_WIDTH = 64;
  localparam int unsigned MEM_DEFAULT_BDEPTH     = 4096;

  // Byte offset of an address inside the window; wraps for addresses below base.
  function automatic logic [63:0] mem_offset(input logic [63:0] addr,
                                             input logic [63:0] base);
    return addr - base;
  endfunction

  // An offset is serviceable only if it lands inside the storage.
  function automatic logic mem_in_range(input logic [63:0] offset,
                                        input logic [63:0] depth);
    return offset < depth;
  endfunction

endpackage

// File: rtl/mem_responder_store.sv
// Byte-lane storage for mem_responder: aligned word read, byte-masked write.
// Contents are deliberately not reset so preloaded data survives a reset.
module mem_responder_store
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BDEPTH = MEM_DEFAULT_BDEPTH,
  parameter int unsigned DATA_WIDTH = MEM_DEFAULT_DATA_WIDTH
) (
  input  logic                                               clk,
  input  logic                                               i_we,
  input  logic [$clog2(MEM_BDEPTH/(DATA_WIDTH/8))-1:0]       i_widx,
  input  logic [DATA_WIDTH-1:0]                              i_wdata,
  input  logic [DATA_WIDTH/8-1:0]                            i_wmask,
  output logic [DATA_WIDTH-1:0]                              o_rdata
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned WORDS = MEM_BDEPTH / NB;

  logic [NB-1:0][7:0] r_mem [WORDS];

  // Aligned read of the addressed word; the top samples it at the access edge.
  assign o_rdata = r_mem[i_widx];

  // Masked write: only lanes with their mask bit set are updated.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (i_we && i_wmask[b]) begin
        r_mem[i_widx][b] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a fixed access latency.
// The request is latched on acceptance, the storage is touched once when the
// latency counter expires, and the response is held until the initiator takes it.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BDEPTH = MEM_DEFAULT_BDEPTH,
  parameter int unsigned DATA_WIDTH = MEM_DEFAULT_DATA_WIDTH,
  parameter logic [63:0] BASE_ADDR  = MEM_BASE_ADDR,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_addr,
  input  logic                    req_wen,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned NBW    = $clog2(NB);
  localparam int unsigned AW     = $clog2(MEM_BDEPTH);
  localparam int unsigned WIDX_W = AW - NBW;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  state_e                  r_state;
  state_e                  w_state_n;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_n;
  logic                    w_accept;
  logic                    w_access;

  logic [63:0]             r_addr;
  logic                    r_wen;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [NB-1:0]           r_wmask;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;

  logic [63:0]             w_offset;
  logic                    w_in_range;
  logic [WIDX_W-1:0]       w_widx;
  logic                    w_store_we;
  logic [DATA_WIDTH-1:0]   w_store_rdata;

  assign w_offset   = mem_offset(r_addr, BASE_ADDR);
  assign w_in_range = mem_in_range(w_offset, 64'(MEM_BDEPTH));
  assign w_widx     = w_offset[AW-1:NBW];
  assign w_store_we = w_access && w_in_range && r_wen;

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;

  // Next-state and counter logic; the access strobe fires on the last BUSY edge.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_accept  = 1'b0;
    w_access  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept  = 1'b1;
          w_state_n = ST_BUSY;
          w_cnt_n   = LAT_M1;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_access  = 1'b1;
          w_state_n = ST_RESP;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_n = ST_IDLE;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Request capture on acceptance; the initiator may change its inputs afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_wen   <= req_wen;
      r_wdata <= req_wdata;
      r_wmask <= req_wmask;
    end
  end

  // Response capture at the access edge; held untouched for the whole RESP phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_err   <= ~w_in_range;
      r_rdata <= (w_in_range && !r_wen) ? w_store_rdata : '0;
    end
  end

  mem_responder_store #(
    .MEM_BDEPTH (MEM_BDEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_store (
    .clk     (clk),
    .i_we    (w_store_we),
    .i_widx  (w_widx),
    .i_wdata (r_wdata),
    .i_wmask (r_wmask),
    .o_rdata (w_store_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic against a byte-array reference model, on a LATENCY=2 instance (a_)
// and a LATENCY=1 instance (b_) driven back-to-back.
module tb_mem_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int unsigned DEPTH = 4096;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic [7:0]  req_wmask;

  logic        b_req_valid, b_req_ready, b_req_wen, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [63:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [7:0]  b_req_wmask;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl_a [DEPTH];
  logic [7:0] mdl_b [DEPTH];

  mem_responder #(.LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  mem_responder #(.LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .req_wen(b_req_wen), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: window check by plain subtraction, aligned little-endian word.
  function automatic void ref_access(input bit sel, input logic [63:0] addr,
                                     input logic wen, input logic [63:0] wdata,
                                     input logic [7:0] wmask,
                                     output logic [63:0] rd, output logic err);
    logic [63:0] off;
    int unsigned base;
    off = addr - BASE;
    rd  = '0;
    err = 1'b0;
    if (off >= 64'(DEPTH)) begin
      err = 1'b1;
      return;
    end
    base = int'(off[11:0]) & 32'hFFFF_FFF8;
    for (int b = 0; b < 8; b++) begin
      if (wen) begin
        if (wmask[b]) begin
          if (sel) mdl_b[base + b] = wdata[8*b +: 8];
          else     mdl_a[base + b] = wdata[8*b +: 8];
        end
      end else begin
        rd[8*b +: 8] = sel ? mdl_b[base + b] : mdl_a[base + b];
      end
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err), 64'd0);
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send_req(input logic [63:0] addr, input logic wen,
                          input logic [63:0] wd, input logic [7:0] wm, output bit ok);
    ok = 1'b0;
    req_addr = addr; req_wen = wen; req_wdata = wd; req_wmask = wm;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp(input int lat);
    for (int k = 0; k < lat; k++) begin
      chk("busy_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("busy_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("rsp_valid_at_latency", 64'(rsp_valid), 64'd1);
  endtask

  task automatic finish_rsp(input logic [63:0] xrd, input logic xerr, input int hold);
    chk("rsp_rdata", rsp_rdata, xrd);
    chk("rsp_err", 64'(rsp_err), 64'(xerr));
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rdata", rsp_rdata, xrd);
      chk("hold_err", 64'(rsp_err), 64'(xerr));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("post_hs_req_ready", 64'(req_ready), 64'd1);
    chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  // One full transaction on instance A. noise keeps req_valid high with a bogus
  // address while BUSY/RESP, which must be ignored.
  task automatic txn(input logic [63:0] addr, input logic wen, input logic [63:0] wd,
                     input logic [7:0] wm, input int hold, input bit busy_rdy,
                     input bit noise, input bit use_exp,
                     input logic [63:0] xrd, input logic xerr);
    logic [63:0] mrd;
    logic        merr;
    bit          ok;
    ref_access(1'b0, addr, wen, wd, wm, mrd, merr);
    if (use_exp) begin
      mrd  = xrd;
      merr = xerr;
    end
    send_req(addr, wen, wd, wm, ok);
    if (!ok) return;
    if (noise) begin
      req_valid = 1'b1;
      req_addr  = BASE + 64'(8 * $urandom_range(0, 31));
      req_wen   = 1'b1;
      req_wdata = {$urandom, $urandom};
      req_wmask = 8'hFF;
    end
    rsp_ready = busy_rdy;
    wait_rsp(2);
    finish_rsp(mrd, merr, hold);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  typedef struct {
    logic [63:0] rd;
    logic        err;
  } exp_t;

  initial begin
    bit          ok;
    logic [63:0] w;
    logic [63:0] a;
    req_t        bl[$];
    req_t        r;
    exp_t        bq[$];
    exp_t        e;
    int          bi;
    int          last_acc;
    int          nrsp;
    bit          acc;

    for (int i = 0; i < int'(DEPTH); i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
    rst = 1'b1;
    req_valid = 0; req_addr = '0; req_wen = 0; req_wdata = '0; req_wmask = '0; rsp_ready = 0;
    b_req_valid = 0; b_req_addr = '0; b_req_wen = 0; b_req_wdata = '0; b_req_wmask = '0; b_rsp_ready = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    // Preload the lowest 32 words through ordinary full-mask writes.
    for (int i = 0; i < 32; i++) begin
      if (i == 0)      w = 64'h0706050403020100;
      else if (i == 1) w = '0;
      else             w = {$urandom, $urandom};
      txn(BASE + 64'(8 * i), 1'b1, w, 8'hFF, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    end

    txn(BASE, 1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b1, 64'h0706050403020100, 1'b0);

    txn(BASE + 64'd8, 1'b1, 64'hAABBCCDDEEFF0011, 8'h0F, 0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    txn(BASE + 64'd8, 1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b1, 64'h00000000EEFF0011, 1'b0);

    txn(64'h0000_0000_8000_1000, 1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b1, '0, 1'b1);
    txn(64'h0000_0000_7FFF_FFF8, 1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b1, '0, 1'b1);
    txn(64'h0000_0000_8000_1000, 1'b1, '1, 8'hFF, 0, 1'b0, 1'b0, 1'b1, '0, 1'b1);
    txn(64'h0000_0000_7FFF_FFF8, 1'b1, '1, 8'hFF, 0, 1'b0, 1'b0, 1'b1, '0, 1'b1);
    txn(BASE, 1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b1, 64'h0706050403020100, 1'b0);
    txn(BASE + 64'd8, 1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b1, 64'h00000000EEFF0011, 1'b0);

    // Response back-pressure for 5 cycles on an unaligned read.
    txn(BASE + 64'd11, 1'b0, '0, '0, 5, 1'b0, 1'b0, 1'b1, 64'h00000000EEFF0011, 1'b0);

    // Reset while a read response is pending: the response is dropped.
    send_req(BASE, 1'b0, '0, '0, ok);
    if (ok) begin
      wait_rsp(2);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_resp");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("after_rst_resp");
    end

    // Reset one cycle after a write is accepted: storage keeps the old word.
    send_req(BASE + 64'd16, 1'b1, 64'h1122334455667788, 8'hFF, ok);
    if (ok) begin
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_busy");
      @(posedge clk); #1;
      check_reset_outputs("rst_busy_hold");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
    end
    txn(BASE + 64'd16, 1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Randomized traffic on instance A.
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 8)       a = BASE + 64'(8 * $urandom_range(0, 31) + $urandom_range(0, 7));
      else if (kind == 8) a = BASE + 64'(DEPTH) + 64'($urandom_range(0, 65535));
      else                a = BASE - 64'd1 - 64'($urandom_range(0, 4095));
      txn(a, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'b0, '0, 1'b0);
    end

    // Instance B (LATENCY=1): continuous requests and ready, one accept every 3 cycles.
    for (int i = 0; i < 4; i++) begin
      r.addr = BASE + 64'(8 * i); r.wen = 1'b1; r.wdata = {$urandom, $urandom}; r.wmask = 8'hFF;
      bl.push_back(r);
    end
    for (int i = 3; i >= 0; i--) begin
      r.addr = BASE + 64'(8 * i + $urandom_range(0, 7)); r.wen = 1'b0; r.wdata = '0; r.wmask = '0;
      bl.push_back(r);
    end
    r.addr = BASE + 64'(DEPTH); r.wen = 1'b0; r.wdata = '0; r.wmask = '0;
    bl.push_back(r);
    r.addr = BASE + 64'd2; r.wen = 1'b1; r.wdata = {$urandom, $urandom}; r.wmask = 8'hA5;
    bl.push_back(r);
    r.addr = BASE; r.wen = 1'b0; r.wdata = '0; r.wmask = '0;
    bl.push_back(r);

    bi = 0;
    last_acc = -100;
    nrsp = 0;
    b_req_addr = bl[0].addr; b_req_wen = bl[0].wen; b_req_wdata = bl[0].wdata; b_req_wmask = bl[0].wmask;
    b_req_valid = 1'b1;
    b_rsp_ready = 1'b1;
    for (int c = 0; c < 80 && nrsp < bl.size(); c++) begin
      @(negedge clk);
      chk("b_req_ready", 64'(b_req_ready), 64'(c >= last_acc + 3));
      chk("b_rsp_valid", 64'(b_rsp_valid), 64'(c == last_acc + 2));
      if (b_rsp_valid === 1'b1) begin
        if (bq.size() > 0) begin
          e = bq.pop_front();
          chk("b_rsp_rdata", b_rsp_rdata, e.rd);
          chk("b_rsp_err", 64'(b_rsp_err), 64'(e.err));
        end
        nrsp++;
      end
      acc = (b_req_valid === 1'b1) && (b_req_ready === 1'b1);
      if (acc) begin
        ref_access(1'b1, b_req_addr, b_req_wen, b_req_wdata, b_req_wmask, e.rd, e.err);
        bq.push_back(e);
        last_acc = c;
      end
      @(posedge clk); #1;
      if (acc) begin
        bi++;
        if (bi < bl.size()) begin
          b_req_addr = bl[bi].addr; b_req_wen = bl[bi].wen;
          b_req_wdata = bl[bi].wdata; b_req_wmask = bl[bi].wmask;
        end else begin
          b_req_valid = 1'b0;
        end
      end
    end
    chk("b_all_responses", 64'(nrsp), 64'(bl.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
